// File: rtl/alu_operand_stage.sv
// rtl/alu_operand_stage.sv - operand staging stage feeding the ALU
//
// Purpose:
//   Fetches two operands through the single register-file read port (A first,
//   then B), applies a one-bit shifter to B and the asel/bsel source muxes, and
//   presents Ain/Bin to the ALU under a valid/ready handshake.
//
// Ports:
//   clk      in   1      rising-edge clock
//   reset_n  in   1      asynchronous active-low reset
//   start    in   1      request a new operand fetch (sampled only when accepted)
//   rn       in   RSEL   register number for operand A
//   rm       in   RSEL   register number for operand B
//   shift    in   2      shifter op on B: 00 none, 01 LSL1, 10 LSR1, 11 ASR1
//   asel     in   1      1: Ain = 0, 0: Ain = A register
//   bsel     in   1      1: Bin = sximm5, 0: Bin = shifted B register
//   sximm5   in   WIDTH  sign-extended immediate, captured on accept
//   readnum  out  RSEL   register-file read select
//   rd_data  in   WIDTH  register-file read data (combinational from readnum)
//   Ain      out  WIDTH  ALU operand A
//   Bin      out  WIDTH  ALU operand B
//   valid    out  1      Ain/Bin valid for the ALU
//   ready    in   1      ALU consumes the operands this cycle
//   busy     out  1      stage is not idle

module alu_operand_stage #(
  parameter int WIDTH = 16,
  parameter int RSEL  = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [RSEL-1:0]  rn,
  input  logic [RSEL-1:0]  rm,
  input  logic [1:0]       shift,
  input  logic             asel,
  input  logic             bsel,
  input  logic [WIDTH-1:0] sximm5,
  output logic [RSEL-1:0]  readnum,
  input  logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] Ain,
  output logic [WIDTH-1:0] Bin,
  output logic             valid,
  input  logic             ready,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD_A = 2'd1,
    S_RD_B = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL1 = 2'b01;
  localparam logic [1:0] SH_LSR1 = 2'b10;
  localparam logic [1:0] SH_ASR1 = 2'b11;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [RSEL-1:0]  r_rn_q;
  logic [RSEL-1:0]  r_rm_q;
  logic [1:0]       r_shift_q;
  logic             r_asel_q;
  logic             r_bsel_q;
  logic [WIDTH-1:0] r_sximm5_q;

  logic             w_accept;
  logic             w_ld_a;
  logic             w_ld_b;
  logic [WIDTH-1:0] w_b_shifted;

  // A new request is only taken when the stage is empty or when the current
  // result is being consumed this cycle; starts during a fetch are dropped.
  assign w_accept = start && ((r_state == S_IDLE) ||
                              ((r_state == S_OUT) && ready));

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and outputs
  always_comb begin
    w_state_nxt = r_state;
    readnum     = '0;
    valid       = 1'b0;
    w_ld_a      = 1'b0;
    w_ld_b      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_RD_A;
        end
      end
      S_RD_A: begin
        readnum     = r_rn_q;
        w_ld_a      = 1'b1;
        w_state_nxt = S_RD_B;
      end
      S_RD_B: begin
        readnum     = r_rm_q;
        w_ld_b      = 1'b1;
        w_state_nxt = S_OUT;
      end
      S_OUT: begin
        valid = 1'b1;
        if (ready) begin
          w_state_nxt = w_accept ? S_RD_A : S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign busy = (r_state != S_IDLE);

  // Request fields are captured only on accept so Ain/Bin stay frozen while
  // valid is high, whatever the inputs do.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rn_q     <= '0;
      r_rm_q     <= '0;
      r_shift_q  <= SH_NONE;
      r_asel_q   <= 1'b0;
      r_bsel_q   <= 1'b0;
      r_sximm5_q <= '0;
    end else if (w_accept) begin
      r_rn_q     <= rn;
      r_rm_q     <= rm;
      r_shift_q  <= shift;
      r_asel_q   <= asel;
      r_bsel_q   <= bsel;
      r_sximm5_q <= sximm5;
    end
  end

  // Operand registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_a <= '0;
      r_b <= '0;
    end else begin
      if (w_ld_a) begin
        r_a <= rd_data;
      end
      if (w_ld_b) begin
        r_b <= rd_data;
      end
    end
  end

  // One-bit shifter on B
  always_comb begin
    w_b_shifted = r_b;
    case (r_shift_q)
      SH_NONE: w_b_shifted = r_b;
      SH_LSL1: w_b_shifted = {r_b[WIDTH-2:0], 1'b0};
      SH_LSR1: w_b_shifted = {1'b0, r_b[WIDTH-1:1]};
      SH_ASR1: w_b_shifted = {r_b[WIDTH-1], r_b[WIDTH-1:1]};
      default: w_b_shifted = r_b;
    endcase
  end

  // Source muxes
  assign Ain = r_asel_q ? '0 : r_a;
  assign Bin = r_bsel_q ? r_sximm5_q : w_b_shifted;

endmodule

// File: tb/tb_alu_operand_stage.sv
// tb/tb_alu_operand_stage.sv - directed self-checking bench for alu_operand_stage

module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [2:0]  rn;
  logic [2:0]  rm;
  logic [1:0]  shift;
  logic        asel;
  logic        bsel;
  logic [15:0] sximm5;
  logic [2:0]  readnum;
  logic [15:0] rd_data;
  logic [15:0] Ain;
  logic [15:0] Bin;
  logic        valid;
  logic        ready;
  logic        busy;

  logic [15:0] regs [8];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign rd_data = regs[readnum];

  alu_operand_stage #(.WIDTH(16), .RSEL(3)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .rn      (rn),
    .rm      (rm),
    .shift   (shift),
    .asel    (asel),
    .bsel    (bsel),
    .sximm5  (sximm5),
    .readnum (readnum),
    .rd_data (rd_data),
    .Ain     (Ain),
    .Bin     (Bin),
    .valid   (valid),
    .ready   (ready),
    .busy    (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues a request from IDLE and walks it to OUT, checking the read sequence.
  task automatic fetch(input logic [2:0] t_rn, input logic [2:0] t_rm, input logic [1:0] t_sh,
                       input logic t_asel, input logic t_bsel, input logic [15:0] t_imm);
    rn = t_rn; rm = t_rm; shift = t_sh; asel = t_asel; bsel = t_bsel; sximm5 = t_imm;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("rda_readnum", 32'(readnum), 32'(t_rn));
    check("rda_valid", 32'(valid), 32'd0);
    check("rda_busy", 32'(busy), 32'd1);
    tick();
    check("rdb_readnum", 32'(readnum), 32'(t_rm));
    check("rdb_valid", 32'(valid), 32'd0);
    tick();
    check("out_valid", 32'(valid), 32'd1);
    check("out_readnum", 32'(readnum), 32'd0);
  endtask

  task automatic consume();
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("consume_valid", 32'(valid), 32'd0);
    check("consume_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) regs[i] = 16'(i);
    regs[1] = 16'd9;
    regs[2] = 16'd2;
    regs[3] = 16'h8003;
    regs[7] = 16'h7777;
    reset_n = 1'b0; start = 1'b0; rn = '0; rm = '0; shift = '0;
    asel = 1'b0; bsel = 1'b0; sximm5 = '0; ready = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ain", 32'(Ain), 32'd0);
    check("rst_bin", 32'(Bin), 32'd0);
    check("rst_readnum", 32'(readnum), 32'd0);
    reset_n = 1'b1;
    tick();

    // Plain fetch
    fetch(3'd1, 3'd2, 2'b00, 1'b0, 1'b0, 16'h0000);
    check("plain_ain", 32'(Ain), 32'h9);
    check("plain_bin", 32'(Bin), 32'h2);
    consume();

    // Shifter
    fetch(3'd1, 3'd3, 2'b00, 1'b0, 1'b0, 16'h0000);
    check("sh00_bin", 32'(Bin), 32'h8003);
    consume();
    fetch(3'd1, 3'd3, 2'b01, 1'b0, 1'b0, 16'h0000);
    check("lsl1_bin", 32'(Bin), 32'h0006);
    consume();
    fetch(3'd1, 3'd3, 2'b10, 1'b0, 1'b0, 16'h0000);
    check("lsr1_bin", 32'(Bin), 32'h4001);
    consume();
    fetch(3'd1, 3'd3, 2'b11, 1'b0, 1'b0, 16'h0000);
    check("asr1_bin", 32'(Bin), 32'hC001);
    check("asr1_ain", 32'(Ain), 32'h9);
    consume();

    // Muxes and immediate hold
    fetch(3'd1, 3'd2, 2'b00, 1'b1, 1'b1, 16'hFFF0);
    check("mux_ain", 32'(Ain), 32'h0);
    check("mux_bin", 32'(Bin), 32'hFFF0);
    sximm5 = 16'h1234; asel = 1'b0; bsel = 1'b0;
    tick();
    check("imm_hold_bin", 32'(Bin), 32'hFFF0);
    check("imm_hold_ain", 32'(Ain), 32'h0);
    consume();

    // rn == rm
    fetch(3'd2, 3'd2, 2'b00, 1'b0, 1'b0, 16'h0000);
    check("same_ain", 32'(Ain), 32'h2);
    check("same_bin", 32'(Bin), 32'h2);
    consume();

    // Backpressure then back-to-back accept
    fetch(3'd1, 3'd2, 2'b00, 1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < 5; i++) begin
      rn = 3'(i); rm = 3'(i + 1); shift = 2'(i); sximm5 = 16'(i * 7);
      tick();
      check("bp_valid", 32'(valid), 32'd1);
      check("bp_ain", 32'(Ain), 32'h9);
      check("bp_bin", 32'(Bin), 32'h2);
    end
    rn = 3'd2; rm = 3'd1; shift = 2'b00; asel = 1'b0; bsel = 1'b0;
    ready = 1'b1; start = 1'b1;
    tick();
    ready = 1'b0; start = 1'b0;
    check("b2b_busy", 32'(busy), 32'd1);
    check("b2b_valid", 32'(valid), 32'd0);
    check("b2b_readnum_a", 32'(readnum), 32'd2);
    tick();
    check("b2b_readnum_b", 32'(readnum), 32'd1);
    tick();
    check("b2b_out_valid", 32'(valid), 32'd1);
    check("b2b_ain", 32'(Ain), 32'h2);
    check("b2b_bin", 32'(Bin), 32'h9);
    consume();

    // Start during RD_A is ignored
    rn = 3'd1; rm = 3'd2; start = 1'b1;
    tick();
    rn = 3'd7; start = 1'b1;
    tick();
    start = 1'b0;
    check("ign_readnum", 32'(readnum), 32'd2);
    tick();
    check("ign_valid", 32'(valid), 32'd1);
    check("ign_ain", 32'(Ain), 32'h9);
    consume();
    tick();
    check("ign_no_extra_valid", 32'(valid), 32'd0);
    check("ign_no_extra_busy", 32'(busy), 32'd0);

    // Reset during RD_B
    rn = 3'd1; rm = 3'd2; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("pre_rst_readnum", 32'(readnum), 32'd2);
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ain", 32'(Ain), 32'd0);
    check("mid_rst_bin", 32'(Bin), 32'd0);
    check("mid_rst_readnum", 32'(readnum), 32'd0);
    tick(); tick();
    reset_n = 1'b1;
    tick(); tick(); tick();
    check("post_rst_valid", 32'(valid), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
